regfile_dump_ctrl: RTL and testbench

REGFILE_DUMP_CTRL -- requirements
Module: regfile_dump_ctrl

---
 rtl/regfile_dump_ctrl.sv | 109 ++++++++++
 tb/tb_regfile_dump_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_ctrl.sv
// Register-file dump sequencer: walks every register through a second read port
// and streams each word to a UART transmitter as bytes, most significant byte first.
//
// state | meaning
// IDLE  | waiting for a dump request while the pipeline is halted
// LOAD  | capture the word at the current address into the shift register
// SEND  | offer the top byte; shift on handshake until the last byte goes out
// NEXT  | advance the address or finish after the last register
// DONE  | one-cycle completion pulse, then back to IDLE
module regfile_dump_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_halted,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int BCW       = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [BCW-1:0]        LAST_BYTE = BCW'(NUM_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        NEXT,
        DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [BCW-1:0]        byte_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;

    // Status flags are registered alongside each state transition so the
    // outputs come straight from flops.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            addr_cnt   <= '0;
            byte_cnt   <= '0;
            shift_reg  <= '0;
            o_tx_valid <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start && i_halted) begin
                        addr_cnt <= '0;
                        o_busy   <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    shift_reg  <= i_rd_data;
                    byte_cnt   <= '0;
                    o_tx_valid <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    if (i_tx_ready) begin
                        if (byte_cnt == LAST_BYTE) begin
                            o_tx_valid <= 1'b0;
                            state      <= NEXT;
                        end else begin
                            shift_reg <= shift_reg << 8;
                            byte_cnt  <= byte_cnt + 1'b1;
                        end
                    end
                end
                NEXT: begin
                    if (addr_cnt == LAST_ADDR) begin
                        o_done <= 1'b1;
                        state  <= DONE;
                    end else begin
                        addr_cnt <= addr_cnt + 1'b1;
                        state    <= LOAD;
                    end
                end
                DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    o_tx_valid <= 1'b0;
                    o_busy     <= 1'b0;
                    o_done     <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign o_rd_addr = addr_cnt;
    assign o_tx_data = shift_reg[DATA_WIDTH-1 -: 8];

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Directed bench for regfile_dump_ctrl: full dumps under steady, random and
// stalled ready, start filtering, and reset in the middle of a dump.
module tb_regfile_dump_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        halted;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    int vectors     = 0;
    int miscompares = 0;

    regfile_dump_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_start    (start),
        .i_halted   (halted),
        .o_rd_addr  (rd_addr),
        .i_rd_data  (rd_data),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready),
        .o_busy     (busy),
        .o_done     (done)
    );

    always #5 clk = ~clk;

    // r[k] = 32'h01000000*k + k
    assign rd_data = {3'b000, rd_addr, 16'h0000, 3'b000, rd_addr};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int n);
        int k;
        int p;
        k = n / 4;
        p = n % 4;
        return (p == 0 || p == 3) ? 8'(k) : 8'h00;
    endfunction

    // ready mode: 0 = always high, 1 = random, 2 = low for 50 cycles inside register 31
    task automatic run_dump(input int mode, input bit poke_start,
                            output int nbytes, output int done_cyc, output int stalls,
                            output int bad_data, output int bad_hold);
        logic [7:0] prev_data;
        bit         prev_stall;
        int         low_cnt;
        nbytes = 0; done_cyc = -1; stalls = 0; bad_data = 0; bad_hold = 0;
        prev_stall = 0; prev_data = 8'h00; low_cnt = 0;
        start = 1'b1;
        halted = 1'b1;
        for (int cyc = 1; cyc <= 20000; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (cyc == 3) halted = 1'b0;
            if (cyc == 10) halted = 1'b1;
            if (poke_start && (cyc == 40 || cyc == 100 || done)) start = 1'b1;
            if (prev_stall && (!tx_valid || tx_data !== prev_data)) bad_hold++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            case (mode)
                1:       tx_ready = 1'($urandom_range(0, 1));
                2: begin
                    tx_ready = 1'b1;
                    if (tx_valid && rd_addr == 5'd31 && low_cnt < 50) begin
                        tx_ready = 1'b0;
                        low_cnt++;
                    end
                end
                default: tx_ready = 1'b1;
            endcase
            if (tx_valid && !tx_ready) stalls++;
            if (tx_valid && tx_ready) begin
                if (tx_data !== exp_byte(nbytes) || int'(rd_addr) != nbytes / 4) bad_data++;
                nbytes++;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    endtask

    int nb, dc, st, bd, bh, bad, hs;
    bit found;

    initial begin
        rst = 1'b1; start = 1'b0; halted = 1'b0; tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rd_addr", int'(rd_addr), 0);
        check("reset_tx_data", int'(tx_data), 0);
        check("reset_tx_valid", int'(tx_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // full dump, ready always high
        run_dump(0, 1'b0, nb, dc, st, bd, bh);
        check("full_bytes", nb, 128);
        check("full_data", bd, 0);
        check("full_done_cycle", dc, 193);
        @(posedge clk); #1;
        check("full_done_pulse", int'(done), 0);
        check("full_idle_busy", int'(busy), 0);

        // random ready
        run_dump(1, 1'b0, nb, dc, st, bd, bh);
        check("rand_bytes", nb, 128);
        check("rand_data", bd, 0);
        check("rand_hold", bh, 0);
        check("rand_done_cycle", dc, 193 + st);
        @(posedge clk); #1;

        // start without halted is ignored
        start = 1'b1; halted = 1'b0; tx_ready = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (busy || tx_valid) bad++;
        end
        check("nohalt_activity", bad, 0);

        // start pokes during the dump and during DONE
        run_dump(0, 1'b1, nb, dc, st, bd, bh);
        check("poke_bytes", nb, 128);
        check("poke_data", bd, 0);
        check("poke_done_cycle", dc, 193);
        @(posedge clk); #1;
        start = 1'b0;
        check("poke_after_done_busy", int'(busy), 0);
        @(posedge clk); #1;

        // ready held low 50 cycles inside register 31
        run_dump(2, 1'b0, nb, dc, st, bd, bh);
        check("stall_bytes", nb, 128);
        check("stall_data", bd, 0);
        check("stall_hold", bh, 0);
        check("stall_count", st, 50);
        check("stall_done_cycle", dc, 243);
        @(posedge clk); #1;

        // reset during third byte of register 5
        start = 1'b1; halted = 1'b1; tx_ready = 1'b1;
        hs = 0; found = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (tx_valid && hs == 22) begin
                found = 1;
                break;
            end
            if (tx_valid && tx_ready) hs++;
        end
        check("midreset_reached", int'(found), 1);
        check("midreset_addr", int'(rd_addr), 5);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midreset_valid", int'(tx_valid), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_done", int'(done), 0);
        check("midreset_rd_addr", int'(rd_addr), 0);
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (done || tx_valid) bad++;
        end
        check("midreset_quiet", bad, 0);
        run_dump(0, 1'b0, nb, dc, st, bd, bh);
        check("restart_bytes", nb, 128);
        check("restart_data", bd, 0);
        check("restart_done_cycle", dc, 193);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
